// File: rtl/fpu_round_normalize.sv
// -----------------------------------------------------------------------------
// fpu_round_normalize
//
// Back end of a single-precision multiplier. It takes the raw 48-bit product of
// two 24-bit significands, normalizes it, rounds it to nearest-even and packs
// an IEEE-754 single-precision result with {Overflow, Underflow, Inexact} flags.
//
// Two pipeline stages, each with its own valid bit and a ready/valid handshake
// on both sides:
//   S1 (normalize) : picks the leading one, extracts 23 fraction bits, guard
//                    and sticky, and adjusts the exponent.
//   S2 (round/pack): round-to-nearest-even, range checks, special overrides,
//                    registered Result/Flags.
//
// Ports
//   CLK       in   1   clock, rising edge
//   RSTn      in   1   synchronous active-low reset
//   InValid   in   1   raw product presented
//   InReady   out  1   product accepted this cycle (combinational)
//   Sign      in   1   product sign
//   Exponent  in  10   signed exponent sum, already in biased form
//   Mantissa  in  48   raw product, leading one at bit 47 or bit 46
//   Special   in   2   00 normal, 01 zero, 10 infinity, 11 NaN
//   OutValid  out  1   Result/Flags valid
//   OutReady  in   1   downstream consumes Result this cycle
//   Result    out 32   packed single-precision result
//   Flags     out  3   {Overflow, Underflow, Inexact}
// -----------------------------------------------------------------------------
module fpu_round_normalize #(
  parameter logic [31:0] NAN_PATTERN = 32'h7FC00000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        InValid,
  output logic        InReady,
  input  logic        Sign,
  input  logic [9:0]  Exponent,
  input  logic [47:0] Mantissa,
  input  logic [1:0]  Special,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] Result,
  output logic [2:0]  Flags
);

  localparam logic [1:0] SP_ZERO = 2'b01;
  localparam logic [1:0] SP_INF  = 2'b10;
  localparam logic [1:0] SP_NAN  = 2'b11;

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s1_adv;
  logic s2_adv;

  // S2 may take a new entry when empty or when its content leaves this cycle;
  // S1 likewise when empty or when it can move into S2.
  assign s2_adv   = !s2_valid_reg || OutReady;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign InReady  = s1_adv;
  assign OutValid = s2_valid_reg;

  // ---------------------------------------------------------------------------
  // S1: normalize
  // ---------------------------------------------------------------------------
  logic        lead_hi;          // product in [2,4): leading one at bit 47
  logic [23:0] low_or;           // low_or[k] = OR of Mantissa[k-1:0]
  logic [22:0] s1_frac_next;
  logic        s1_guard_next;
  logic        s1_sticky_next;
  logic [10:0] s1_exp_next;

  assign lead_hi   = Mantissa[47];
  assign low_or[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < 24; gi++) begin : g_low_or
      assign low_or[gi] = low_or[gi-1] | Mantissa[gi-1];
    end
    // The leading one itself is implicit; only the 23 bits below it are kept.
    // When the product is in [2,4) the window slides up by one, which is the
    // same as shifting right by one with the dropped bit folded into sticky.
    for (gi = 0; gi < 23; gi++) begin : g_frac
      assign s1_frac_next[gi] = lead_hi ? Mantissa[gi+24] : Mantissa[gi+23];
    end
  endgenerate

  assign s1_guard_next  = lead_hi ? Mantissa[23] : Mantissa[22];
  assign s1_sticky_next = lead_hi ? low_or[23]   : low_or[22];

  // Sign-extend to 11 bits so the normalize and round increments cannot wrap.
  assign s1_exp_next = {Exponent[9], Exponent} + {10'd0, lead_hi};

  logic               s1_sign_reg;
  logic [1:0]         s1_special_reg;
  logic signed [10:0] s1_exp_reg;
  logic [22:0]        s1_frac_reg;
  logic               s1_guard_reg;
  logic               s1_sticky_reg;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      s1_valid_reg <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= InValid;
    end
  end

  // Datapath registers need no reset: they are only observed behind a valid bit.
  always_ff @(posedge CLK) begin
    if (s1_adv && InValid) begin
      s1_sign_reg    <= Sign;
      s1_special_reg <= Special;
      s1_exp_reg     <= s1_exp_next;
      s1_frac_reg    <= s1_frac_next;
      s1_guard_reg   <= s1_guard_next;
      s1_sticky_reg  <= s1_sticky_next;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: round to nearest even, range check, pack
  // ---------------------------------------------------------------------------
  logic               round_up;
  logic               round_carry;
  logic [22:0]        frac_inc;
  logic [22:0]        frac_rounded;
  logic signed [10:0] exp_rounded;
  logic               inexact;
  logic [31:0]        result_next;
  logic [2:0]         flags_next;

  assign round_up     = s1_guard_reg && (s1_sticky_reg || s1_frac_reg[0]);
  assign frac_inc     = s1_frac_reg + 23'd1;
  // An all-ones fraction rounding up gives 2.0: the fraction wraps to zero
  // (significand 1.0) and the exponent takes the carry.
  assign round_carry  = round_up && (&s1_frac_reg);
  assign frac_rounded = round_up ? frac_inc : s1_frac_reg;
  assign exp_rounded  = s1_exp_reg + {10'd0, round_carry};
  assign inexact      = s1_guard_reg || s1_sticky_reg;

  always_comb begin
    result_next = {s1_sign_reg, exp_rounded[7:0], frac_rounded};
    flags_next  = {2'b00, inexact};
    case (s1_special_reg)
      SP_ZERO: begin
        result_next = {s1_sign_reg, 31'h0};
        flags_next  = 3'b000;
      end
      SP_INF: begin
        result_next = {s1_sign_reg, 8'hFF, 23'h0};
        flags_next  = 3'b000;
      end
      SP_NAN: begin
        result_next = NAN_PATTERN;
        flags_next  = 3'b000;
      end
      default: begin
        if (exp_rounded >= 11'sd255) begin
          result_next = {s1_sign_reg, 8'hFF, 23'h0};
          flags_next  = 3'b101;
        end else if (exp_rounded <= 11'sd0) begin
          // No denormals: anything below the normal range flushes to zero.
          result_next = {s1_sign_reg, 31'h0};
          flags_next  = 3'b011;
        end
      end
    endcase
  end

  logic [31:0] result_reg;
  logic [2:0]  flags_reg;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      s2_valid_reg <= 1'b0;
      result_reg   <= 32'h0;
      flags_reg    <= 3'b000;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      // Only load on real data so the outputs hold across bubbles.
      if (s1_valid_reg) begin
        result_reg <= result_next;
        flags_reg  <= flags_next;
      end
    end
  end

  assign Result = result_reg;
  assign Flags  = flags_reg;

endmodule

// File: tb/tb_fpu_round_normalize.sv
// -----------------------------------------------------------------------------
// tb_fpu_round_normalize
//
// Randomized ready/valid stimulus against fpu_round_normalize. Every accepted
// product is pushed into a queue with the result computed by an arithmetic
// model (integer rounding of the exact product); every emitted result is popped
// and compared. Directed vectors pin the model to hand-computed values, and
// dedicated phases cover latency, backpressure and reset mid-stream.
// -----------------------------------------------------------------------------
module tb_fpu_round_normalize;

  localparam logic [31:0] NAN = 32'h7FC00000;

  logic        CLK;
  logic        RSTn;
  logic        InValid;
  logic        InReady;
  logic        Sign;
  logic [9:0]  Exponent;
  logic [47:0] Mantissa;
  logic [1:0]  Special;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Result;
  logic [2:0]  Flags;

  fpu_round_normalize #(.NAN_PATTERN(NAN)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .InValid  (InValid),
    .InReady  (InReady),
    .Sign     (Sign),
    .Exponent (Exponent),
    .Mantissa (Mantissa),
    .Special  (Special),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Result   (Result),
    .Flags    (Flags)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  int rdy_mode = 0;   // 0: OutReady=1, 1: random, 2: held by the main sequence

  logic [34:0] exp_q[$];

  // Reference: value = Mantissa * 2^-46 * 2^(Exponent-127). Round the exact
  // product to 24 significant bits by comparing the discarded remainder with
  // one half ulp.
  function automatic logic [34:0] model(input logic s, input logic signed [9:0] e,
                                        input logic [47:0] m, input logic [1:0] sp);
    longint unsigned mm, sig, rem, half;
    int  sh, be;
    logic up, inx;
    case (sp)
      2'b01: return {3'b000, s, 31'h0};
      2'b10: return {3'b000, s, 8'hFF, 23'h0};
      2'b11: return {3'b000, NAN};
      default: ;
    endcase
    mm   = 64'(m);
    sh   = m[47] ? 24 : 23;
    be   = int'(e) + (m[47] ? 1 : 0);
    sig  = mm >> sh;
    rem  = mm & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    up   = (rem > half) || ((rem == half) && sig[0]);
    inx  = (rem != 0);
    sig  = sig + (up ? 64'd1 : 64'd0);
    if (sig == (64'd1 << 24)) begin
      sig = 64'd1 << 23;
      be  = be + 1;
    end
    if (be >= 255) return {3'b101, s, 8'hFF, 23'h0};
    if (be <= 0)   return {3'b011, s, 31'h0};
    return {2'b00, inx, s, 8'(be), sig[22:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard: samples on the falling edge, mid-cycle.
  // ---------------------------------------------------------------------------
  logic        after_rst  = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [2:0]  prev_flags;

  always @(negedge CLK) begin
    if (!RSTn) begin
      exp_q.delete();
      after_rst  = 1'b1;
      prev_stall = 1'b0;
    end else begin
      if (after_rst) begin
        chk("rst_outvalid", 64'(OutValid), 64'd0);
        chk("rst_result",   64'(Result),   64'd0);
        chk("rst_flags",    64'(Flags),    64'd0);
        chk("rst_inready",  64'(InReady),  64'd1);
        after_rst = 1'b0;
      end
      if (prev_stall) begin
        chk("stall_valid",  64'(OutValid), 64'd1);
        chk("stall_result", 64'(Result),   64'(prev_res));
        chk("stall_flags",  64'(Flags),    64'(prev_flags));
      end
      if (OutValid && OutReady) begin
        n_out++;
        $display("out %0d: result=%h flags=%b", n_out, Result, Flags);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got %h/%b required no output", Result, Flags);
        end else begin
          logic [34:0] w;
          w = exp_q.pop_front();
          chk("sb_result", 64'(Result), 64'(w[31:0]));
          chk("sb_flags",  64'(Flags),  64'(w[34:32]));
        end
      end
      if (InValid && InReady)
        exp_q.push_back(model(Sign, Exponent, Mantissa, Special));
      prev_stall = OutValid && !OutReady;
      prev_res   = Result;
      prev_flags = Flags;
    end
  end

  // OutReady driver
  initial begin
    OutReady = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0:       OutReady = 1'b1;
        1:       OutReady = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m,
                      input logic [1:0] sp);
    int   cnt;
    logic acc;
    Sign = s; Exponent = e; Mantissa = m; Special = sp; InValid = 1'b1;
    cnt = 0;
    do begin
      @(negedge CLK);
      acc = InReady;
      tick();
      cnt++;
    end while (!acc && cnt < 200);
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got InReady=0 for %0d cycles required 1", cnt);
    end
    InValid = 1'b0;
  endtask

  task automatic send_rand();
    logic [47:0] m;
    logic [1:0]  sp;
    int          e, r;
    r  = int'($urandom_range(0, 15));
    sp = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
    case ($urandom_range(0, 3))
      0:       e = int'($urandom_range(0, 1023)) - 512;
      1:       e = int'($urandom_range(250, 256));
      2:       e = int'($urandom_range(0, 6)) - 3;
      default: e = int'($urandom_range(1, 254));
    endcase
    m = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    if ($urandom_range(0, 1) == 1) m[47] = 1'b1;
    else m[47:46] = 2'b01;
    if ($urandom_range(0, 3) == 0)
      m = m[47] ? (m & ~48'h7F_FFFF) : (m & ~48'h3F_FFFF);   // ties / exact
    if ($urandom_range(0, 7) == 0)
      m = m[47] ? (m | 48'h7FFF_FF80_0000) : (m | 48'h3FFF_FFC0_0000); // carry-out
    send(1'($urandom_range(0, 1)), 10'(e), m, sp);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      tick();
      c++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
    end
  endtask

  // Directed vectors with hand-computed results.
  logic        ds   [15];
  logic [9:0]  de   [15];
  logic [47:0] dm   [15];
  logic [1:0]  dsp  [15];
  logic [31:0] dres [15];
  logic [2:0]  dfl  [15];

  initial begin
    int base;
    ds  = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    de  = '{10'd127, 10'd127, 10'd127, 10'd127, 10'd254, 10'h381, 10'd127, 10'd127,
            10'd127, 10'd100, 10'd100, 10'd1, 10'd0, 10'd254, 10'd253};
    dm  = '{48'h9000_0000_0000, 48'h4000_00C0_0000, 48'h4000_0040_0000, 48'h7FFF_FFC0_0000,
            48'h9000_0000_0000, 48'h4000_0000_0000, 48'h4000_0000_0000, 48'h4000_0000_0000,
            48'h4000_0000_0000, 48'h8000_0080_0001, 48'h8000_0180_0000, 48'h4000_0000_0000,
            48'h4000_0000_0000, 48'h7FFF_FFC0_0000, 48'h7FFF_FFC0_0000};
    dsp = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10,
            2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    dres = '{32'h40100000, 32'h3F800002, 32'h3F800000, 32'h40000000, 32'h7F800000,
             32'h80000000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h32800001,
             32'h32800002, 32'h00800000, 32'h00000000, 32'h7F800000, 32'h7F000000};
    dfl  = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b101, 3'b011, 3'b000, 3'b000,
             3'b000, 3'b001, 3'b001, 3'b000, 3'b011, 3'b101, 3'b001};

    RSTn = 1'b0; InValid = 1'b0; Sign = 1'b0; Exponent = '0; Mantissa = '0; Special = '0;
    repeat (3) tick();
    RSTn = 1'b1;

    // Pin the model to the hand-computed expectations.
    for (int i = 0; i < 15; i++)
      chk($sformatf("model_vec%0d", i), 64'(model(ds[i], de[i], dm[i], dsp[i])),
          64'({dfl[i], dres[i]}));

    // Latency: accepted at edge k, visible after edge k+1.
    send(ds[0], de[0], dm[0], dsp[0]);
    @(negedge CLK);
    chk("lat_early_valid", 64'(OutValid), 64'd0);
    @(negedge CLK);
    chk("lat_valid",  64'(OutValid), 64'd1);
    chk("lat_result", 64'(Result),   64'(dres[0]));
    chk("lat_flags",  64'(Flags),    64'(dfl[0]));
    tick();

    // Remaining directed vectors back to back.
    for (int i = 1; i < 15; i++) send(ds[i], de[i], dm[i], dsp[i]);
    drain();

    // Random traffic with bubbles and random backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send_rand();
    end
    rdy_mode = 0;
    OutReady = 1'b1;
    drain();

    // Backpressure: 4 products, OutReady low while the stages fill.
    base = n_out;
    rdy_mode = 2;
    OutReady = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_rand();
      end
      begin
        repeat (3) @(negedge CLK);
        chk("bp_inready",  64'(InReady),  64'd0);
        chk("bp_outvalid", 64'(OutValid), 64'd1);
        tick();
        rdy_mode = 0;
        OutReady = 1'b1;
      end
    join
    drain();
    repeat (3) tick();
    chk("bp_count", 64'(n_out - base), 64'd4);

    // Reset with both stages full: in-flight products must vanish.
    rdy_mode = 2;
    OutReady = 1'b0;
    send_rand();
    send_rand();
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    rdy_mode = 0;
    OutReady = 1'b1;
    base = n_out;
    for (int i = 0; i < 3; i++) send_rand();
    drain();
    repeat (4) tick();
    chk("rst_count", 64'(n_out - base), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
